// File: rtl/exec_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exec_pkg : opcode and FSM encodings for execution_stage_mc.  Rev 1.0
// ---------------------------------------------------------------------------
package exec_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD = 4'd0;
    localparam opcode_t OP_SUB = 4'd1;
    localparam opcode_t OP_AND = 4'd2;
    localparam opcode_t OP_OR  = 4'd3;
    localparam opcode_t OP_XOR = 4'd4;
    localparam opcode_t OP_SLL = 4'd5;
    localparam opcode_t OP_SRA = 4'd6;
    localparam opcode_t OP_SRL = 4'd7;
    localparam opcode_t OP_MUL = 4'd8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL      = 2'd1;
    localparam logic [1:0] ST_MUL_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/execution_stage_mc_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// execution_stage_mc_if : upstream/downstream handshake and sideband bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
interface execution_stage_mc_if
    import exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int WBA_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    opcode_t           alu_opcode;
    logic [DATA_W-1:0] data_in1;
    logic [DATA_W-1:0] data_in2;
    logic [WBA_W-1:0]  wb_addr_in;
    logic              wb_en_in;
    logic              wb_src_in;
    logic              mem_we_in;
    logic [DATA_W-1:0] mem_data_in;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_out;
    logic              zero_out;
    logic [WBA_W-1:0]  wb_addr_out;
    logic              wb_en_out;
    logic              wb_src_out;
    logic              mem_we_out;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output in_valid, alu_opcode, data_in1, data_in2, wb_addr_in, wb_en_in,
               wb_src_in, mem_we_in, mem_data_in, out_ready,
        input  in_ready, out_valid, alu_out, zero_out, wb_addr_out, wb_en_out,
               wb_src_out, mem_we_out, mem_data_out
    );

    modport slave (
        input  in_valid, alu_opcode, data_in1, data_in2, wb_addr_in, wb_en_in,
               wb_src_in, mem_we_in, mem_data_in, out_ready,
        output in_ready, out_valid, alu_out, zero_out, wb_addr_out, wb_en_out,
               wb_src_out, mem_we_out, mem_data_out
    );
endinterface
`default_nettype wire

// File: rtl/exec_mul_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exec_mul_iter : radix-2 shift-add multiplier, one partial product per cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
module exec_mul_iter #(
    parameter int DATA_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_start,
    input  wire logic              i_kill,
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    output logic                   o_done,
    output logic [DATA_W-1:0]      o_product
);
    localparam int              CW     = $clog2(DATA_W);
    localparam logic [CW-1:0]   c_LAST = CW'(DATA_W - 1);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] w_step;

    assign w_step = r_acc + (r_b[0] ? r_a : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_kill) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_acc  <= '0;
            r_a    <= i_a;
            r_b    <= i_b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_step;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    // The final step is visible combinationally so the top can load it on the
    // same edge; afterwards the finished sum stays parked in r_acc.
    assign o_done    = r_busy && (r_cnt == c_LAST);
    assign o_product = r_busy ? w_step : r_acc;

endmodule
`default_nettype wire

// File: rtl/execution_stage_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// execution_stage_mc : ALU + iterative multiply stage with valid/ready on both
// sides and a sync flush.  Rev 1.0
// ---------------------------------------------------------------------------
module execution_stage_mc
    import exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int WBA_W  = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush,
    execution_stage_mc_if.slave    bus
);
    localparam int SHW = $clog2(DATA_W);

    logic [1:0]        r_state;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_alu_out;
    logic              r_zero;
    logic [WBA_W-1:0]  r_wb_addr;
    logic              r_wb_en;
    logic              r_wb_src;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_data;

    logic [WBA_W-1:0]  r_p_wb_addr;
    logic              r_p_wb_en;
    logic              r_p_wb_src;
    logic              r_p_mem_we;
    logic [DATA_W-1:0] r_p_mem_data;

    logic              w_slot_free;
    logic              w_accept;
    logic              w_is_mul;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;
    logic [DATA_W-1:0] w_alu;
    logic [SHW-1:0]    w_sh;
    logic              w_load;
    logic              w_from_mul;
    logic [1:0]        w_next_state;
    logic [DATA_W-1:0] w_res;

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign bus.in_ready = (r_state == ST_IDLE) && w_slot_free && !flush && !rst;
    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_is_mul    = (bus.alu_opcode == OP_MUL);
    assign w_sh        = bus.data_in2[SHW-1:0];

    exec_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_accept && w_is_mul),
        .i_kill    (flush),
        .i_a       (bus.data_in1),
        .i_b       (bus.data_in2),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    always_comb begin
        w_alu = '0;
        case (bus.alu_opcode)
            OP_ADD:  w_alu = bus.data_in1 + bus.data_in2;
            OP_SUB:  w_alu = bus.data_in1 - bus.data_in2;
            OP_AND:  w_alu = bus.data_in1 & bus.data_in2;
            OP_OR:   w_alu = bus.data_in1 | bus.data_in2;
            OP_XOR:  w_alu = bus.data_in1 ^ bus.data_in2;
            OP_SLL:  w_alu = bus.data_in1 << w_sh;
            OP_SRA:  w_alu = $signed(bus.data_in1) >>> w_sh;
            OP_SRL:  w_alu = bus.data_in1 >> w_sh;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_load       = 1'b0;
        w_from_mul   = 1'b0;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) w_next_state = ST_MUL;
                    else          w_load       = 1'b1;
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    if (w_slot_free) begin
                        w_load       = 1'b1;
                        w_from_mul   = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_MUL_DONE;
                    end
                end
            end
            ST_MUL_DONE: begin
                if (w_slot_free) begin
                    w_load       = 1'b1;
                    w_from_mul   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_res = w_from_mul ? w_mul_product : w_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_out_valid  <= 1'b0;
            r_alu_out    <= '0;
            r_zero       <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_en      <= 1'b0;
            r_wb_src     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_data   <= '0;
            r_p_wb_addr  <= '0;
            r_p_wb_en    <= 1'b0;
            r_p_wb_src   <= 1'b0;
            r_p_mem_we   <= 1'b0;
            r_p_mem_data <= '0;
        end else if (flush) begin
            // alu_out and zero_out are deliberately left as they were
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_en     <= 1'b0;
            r_wb_src    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && w_is_mul) begin
                r_p_wb_addr  <= bus.wb_addr_in;
                r_p_wb_en    <= bus.wb_en_in;
                r_p_wb_src   <= bus.wb_src_in;
                r_p_mem_we   <= bus.mem_we_in;
                r_p_mem_data <= bus.mem_data_in;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_alu_out   <= w_res;
                r_zero      <= (w_res == '0);
                r_wb_addr   <= w_from_mul ? r_p_wb_addr  : bus.wb_addr_in;
                r_wb_en     <= w_from_mul ? r_p_wb_en    : bus.wb_en_in;
                r_wb_src    <= w_from_mul ? r_p_wb_src   : bus.wb_src_in;
                r_mem_we    <= w_from_mul ? r_p_mem_we   : bus.mem_we_in;
                r_mem_data  <= w_from_mul ? r_p_mem_data : bus.mem_data_in;
            end
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.alu_out      = r_alu_out;
    assign bus.zero_out     = r_zero;
    assign bus.wb_addr_out  = r_wb_addr;
    assign bus.wb_en_out    = r_wb_en;
    assign bus.wb_src_out   = r_wb_src;
    assign bus.mem_we_out   = r_mem_we;
    assign bus.mem_data_out = r_mem_data;

endmodule
`default_nettype wire
